// File: rtl/screen_display.sv
// 640x480@60 VGA scan generator showing a 128x128 one-bit framebuffer window.
// Three-stage pipeline: counters/decode, framebuffer read, registered outputs.
module screen_display #(
  parameter int          XPOS     = 256,
  parameter int          YPOS     = 176,
  parameter logic [2:0]  FG_COLOR = 3'b010,
  parameter logic [2:0]  BG_COLOR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [2:0]  vga_rgb,
  output logic        frame_tick
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] HS_FIRST = 10'd656;
  localparam logic [9:0] HS_LAST  = 10'd751;
  localparam logic [9:0] VS_FIRST = 10'd490;
  localparam logic [9:0] VS_LAST  = 10'd491;
  localparam logic [9:0] X_LO     = 10'(XPOS);
  localparam logic [9:0] X_HI     = 10'(XPOS + 127);
  localparam logic [9:0] Y_LO     = 10'(YPOS);
  localparam logic [9:0] Y_HI     = 10'(YPOS + 127);

  logic [9:0]  h;
  logic [9:0]  v;

  // stage 0 decode
  logic        active;
  logic        win;
  logic        hs_raw;
  logic        vs_raw;
  logic        tick_raw;
  logic [6:0]  xoff;
  logic [6:0]  yoff;
  logic [10:0] rd_addr;

  // stage 1
  logic [7:0]  mem [0:2047];
  logic [7:0]  rd_byte;
  logic        win_d;
  logic [2:0]  px_d;
  logic        active_d;
  logic        hs_d;
  logic        vs_d;
  logic        tick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // Offsets wrap modulo 128; they are only meaningful inside the window.
  always_comb begin
    active   = (h < H_ACTIVE) && (v < V_ACTIVE);
    win      = (h >= X_LO) && (h <= X_HI) && (v >= Y_LO) && (v <= Y_HI);
    hs_raw   = !((h >= HS_FIRST) && (h <= HS_LAST));
    vs_raw   = !((v >= VS_FIRST) && (v <= VS_LAST));
    tick_raw = (h == 10'd0) && (v == 10'd0);
    xoff     = 7'(h - X_LO);
    yoff     = 7'(v - Y_LO);
    rd_addr  = {yoff, xoff[6:3]};
  end

  // Write port has no back-pressure and ignores rst and scan position.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-first: a same-cycle write to rd_addr is not seen by this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_byte  <= '0;
      win_d    <= 1'b0;
      px_d     <= '0;
      active_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
      tick_d   <= 1'b0;
    end else begin
      rd_byte  <= mem[rd_addr];
      win_d    <= win;
      px_d     <= xoff[2:0];
      active_d <= active;
      hs_d     <= hs_raw;
      vs_d     <= vs_raw;
      tick_d   <= tick_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_rgb    <= 3'b000;
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (!active_d)
        vga_rgb <= 3'b000;
      else if (win_d && rd_byte[px_d])
        vga_rgb <= FG_COLOR;
      else
        vga_rgb <= BG_COLOR;
      vga_hs     <= hs_d;
      vga_vs     <= vs_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_screen_display.sv
// Bench for screen_display: pixel-accurate reference model of the scan plus
// table-driven window/sync vectors and hand-written write-race and reset sequences.
module tb_screen_display;

  localparam int         X     = 500;
  localparam int         Y     = 2;
  localparam logic [2:0] FG    = 3'b010;
  localparam logic [2:0] BG    = 3'b100;
  localparam int         FRAME = 800 * 525;
  localparam logic [5:0] RST_OUT = 6'b110_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        vga_hs;
  logic        vga_vs;
  logic [2:0]  vga_rgb;
  logic        frame_tick;

  screen_display #(
    .XPOS(X), .YPOS(Y), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  logic [7:0] fb [2048];
  logic [5:0] exp_q [$];
  int         pid_q [$];
  logic [5:0] cur_exp;
  int         cur_pid = -1;
  int         pix = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int         h;
    int         v;
    logic [2:0] rgb;
    logic       hs;
    logic       tick;
  } vec_t;
  vec_t tbl [14];

  // Expected {hs, vs, tick, rgb} for scan pixel p, from the display rules.
  function automatic logic [5:0] model_px(input int p);
    int h, v;
    logic [2:0] c;
    h = p % 800;
    v = (p / 800) % 525;
    if (h < 640 && v < 480) begin
      if (h >= X && h < X + 128 && v >= Y && v < Y + 128)
        c = fb[(v - Y) * 16 + (h - X) / 8][(h - X) % 8] ? FG : BG;
      else
        c = BG;
    end else begin
      c = 3'b000;
    end
    return {(h >= 656 && h <= 751) ? 1'b0 : 1'b1,
            (v >= 490 && v <= 491) ? 1'b0 : 1'b1,
            (p == 0) ? 1'b1 : 1'b0, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t pixel=%0d got %0h want %0h", name, $time, cur_pid, act, exp);
    end
  endtask

  // One clock: predict, drive, advance, compare every output.
  task automatic step(input logic r, input logic we, input logic [10:0] a, input logic [7:0] d);
    if (r) begin
      exp_q.delete();
      pid_q.delete();
      exp_q.push_back(RST_OUT);
      exp_q.push_back(RST_OUT);
      pid_q.push_back(-1);
      pid_q.push_back(-1);
      pix = 0;
    end else begin
      exp_q.push_back(model_px(pix));
      pid_q.push_back(pix);
      pix = (pix + 1) % FRAME;
    end
    if (we) fb[a] = d;
    rst = r; wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk);
    @(negedge clk);
    cur_exp = exp_q.pop_front();
    cur_pid = pid_q.pop_front();
    check("outputs", 32'({vga_hs, vga_vs, frame_tick, vga_rgb}), 32'(cur_exp));
  endtask

  task automatic wait_out(input int tp);
    for (int i = 0; i < 60000 && cur_pid != tp; i++) step(1'b0, 1'b0, '0, '0);
    check("reach_pixel", 32'(cur_pid), 32'(tp));
  endtask

  initial begin
    int h, v, k, a, tgt;
    logic [10:0] wa;

    tbl[0]  = '{0,   0, BG,     1'b1, 1'b1};
    tbl[1]  = '{1,   0, BG,     1'b1, 1'b0};
    tbl[2]  = '{499, 2, BG,     1'b1, 1'b0};
    tbl[3]  = '{500, 2, FG,     1'b1, 1'b0};
    tbl[4]  = '{501, 2, BG,     1'b1, 1'b0};
    tbl[5]  = '{627, 2, FG,     1'b1, 1'b0};
    tbl[6]  = '{628, 2, BG,     1'b1, 1'b0};
    tbl[7]  = '{655, 2, 3'b000, 1'b1, 1'b0};
    tbl[8]  = '{656, 2, 3'b000, 1'b0, 1'b0};
    tbl[9]  = '{751, 2, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{752, 2, 3'b000, 1'b1, 1'b0};
    tbl[11] = '{500, 3, BG,     1'b1, 1'b0};
    tbl[12] = '{501, 3, FG,     1'b1, 1'b0};
    tbl[13] = '{502, 3, BG,     1'b1, 1'b0};

    // Reset, then load the whole framebuffer while rst is still held.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 2048; i++) step(1'b1, 1'b1, 11'(i), 8'($urandom));
    step(1'b1, 1'b1, 11'd0,  8'h01);
    step(1'b1, 1'b1, 11'd15, 8'h80);
    step(1'b1, 1'b1, 11'd16, 8'h02);

    foreach (tbl[i]) begin
      wait_out(tbl[i].v * 800 + tbl[i].h);
      check("tbl_rgb",  32'(vga_rgb),    32'(tbl[i].rgb));
      check("tbl_hs",   32'(vga_hs),     32'(tbl[i].hs));
      check("tbl_tick", 32'(frame_tick), 32'(tbl[i].tick));
    end

    // Random writes, often aimed at the byte being read this very cycle.
    for (int i = 0; i < 60000 && pix < 45 * 800; i++) begin
      h = pix % 800;
      v = pix / 800;
      if ($urandom_range(0, 2) == 0 && h >= X && h < X + 128 && v >= Y && v < Y + 128)
        wa = 11'((v - Y) * 16 + (h - X) / 8);
      else
        wa = 11'($urandom_range(0, 1023));
      step(1'b0, 1'($urandom_range(0, 1)), wa, 8'($urandom));
    end

    // Same-cycle write/read race: first pixel keeps old data, rest of byte is new.
    a   = (47 - Y) * 16 + 2;
    tgt = 47 * 800 + X + 16;
    step(1'b0, 1'b1, 11'(a), 8'h00);
    for (int i = 0; i < 5000 && pix != tgt; i++) step(1'b0, 1'b0, '0, '0);
    check("race_align", 32'(pix), 32'(tgt));
    step(1'b0, 1'b1, 11'(a), 8'hFF);
    wait_out(tgt);
    check("race_old", 32'(vga_rgb), 32'(BG));
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, '0, '0);
      check("race_new", 32'(vga_rgb), 32'(FG));
    end

    // Mid-frame reset: outputs idle, tick two cycles after release, memory intact.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, '0);
      check("rst_hs",  32'(vga_hs),  32'd1);
      check("rst_rgb", 32'(vga_rgb), 32'd0);
    end
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0);
      k++;
      if (frame_tick) break;
    end
    check("tick_latency", 32'(k), 32'd2);
    for (int i = 0; i < 4 * 800; i++) step(1'b0, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_display.md
SCREEN_DISPLAY -- requirements
Module: screen_display

Interface
REQ-001 Parameter XPOS, default 256: horizontal pixel position of the left edge of the 128x128 window.
REQ-002 Parameter YPOS, default 176: vertical line position of the top edge of the window.
REQ-003 Parameter FG_COLOR, default 3'b010: colour of a set framebuffer bit.
REQ-004 Parameter BG_COLOR, default 3'b000: colour of a clear framebuffer bit and of everything outside the window.
REQ-005 clk  input  1  pixel clock (25 MHz); the block's only clock.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 wr_en  input  1  framebuffer write strobe from screen_control.
REQ-008 wr_addr  input  11  framebuffer byte address (y*16 + x/8).
REQ-009 wr_data  input  8  framebuffer byte; bit 0 is the leftmost pixel of the byte.
REQ-010 vga_hs  output  1  horizontal sync, active low.
REQ-011 vga_vs  output  1  vertical sync, active low.
REQ-012 vga_rgb  output  3  pixel colour {r,g,b}.
REQ-013 frame_tick  output  1  one-cycle pulse marking pixel (0,0) of each frame.

Function
REQ-014 Internal 2048x8 framebuffer with one write port and one synchronous read port, both on clk.
- Write: on every cycle with wr_en=1, mem[wr_addr] <= wr_data, independent of scan position.
- No handshake or back-pressure on the write port.
REQ-015 Read and write to the same address in the same cycle: the read returns the old data (read-first).
REQ-016 Framebuffer contents are zero at configuration; rst does not clear them.
REQ-017 Horizontal counter h runs 0..799 and wraps to 0; the vertical counter v increments when h wraps and runs 0..524, wrapping to 0.
REQ-018 Stage 0 (counter cycle) decodes the following:
- active = h<640 && v<480.
- win = XPOS<=h<=XPOS+127 && YPOS<=v<=YPOS+127.
- hs_raw = !(656<=h<=751).
- vs_raw = !(490<=v<=491).
- tick_raw = (h==0 && v==0).
REQ-019 Stage 0 read address:
- When win=1, the address is {(v-YPOS)[6:0], (h-XPOS)[6:3]} (11 bits).
- When win=0, the address value is don't-care.
REQ-020 Stage 1 captures the read byte and delays win and px=(h-XPOS)[2:0] by one cycle.
REQ-021 Stage 2 output register is loaded as follows:
- vga_rgb = FG_COLOR if (win_d && byte[px_d]); otherwise BG_COLOR.
- Blanking (active_d=0) forces vga_rgb = 3'b000.
REQ-022 vga_hs, vga_vs and frame_tick are the stage-0 raw signals delayed exactly 2 cycles, aligned with vga_rgb.
REQ-023 Latency: the counter value (h,v) at cycle n appears on all outputs at cycle n+2.
REQ-024 A write landing in cycle n becomes visible on the output at a pixel whose stage-0 read occurs at cycle n+1 or later.
REQ-025 Arithmetic on window offsets is unsigned and truncated to 7 bits; outside the window, the result is unused.

Reset
REQ-026 While rst=1 at a clk edge:
- h and v are set to 0.
- All pipeline registers are cleared.
- vga_hs=1, vga_vs=1, vga_rgb=3'b000, frame_tick=0.
REQ-027 rst asserted mid-frame aborts the frame; the framebuffer and in-flight writes are unaffected.
REQ-028 On the first edge after rst falls, counting restarts from (0,0); frame_tick pulses 2 cycles after that edge.

Verification
REQ-029 Release rst -> frame_tick=1 exactly at cycles 2, 420002, 840002 (800*525 = 420000 cycles per frame).
REQ-030 Free run -> per line, vga_hs is low for exactly 96 cycles starting at output pixel 656; per frame, vga_vs is low for 2 lines starting at line 490.
REQ-031 Write mem[0]=8'h01 -> output pixel (256,176)=3'b010 and pixel (257,176)=3'b000.
REQ-032 Write mem[2047]=8'h80 -> output pixel (383,303)=3'b010; pixel (384,303) and pixel (255,176) remain BG.
REQ-033 Write mem[x]=8'hFF in the same cycle that the read of address x is issued -> that pixel shows old data; the next frame shows FG across all 8 pixels.
REQ-034 Assert rst for 3 cycles at v=200 -> outputs take reset values; framebuffer unchanged; the next frame_tick arrives 2 cycles after rst release.
